// File: rtl/hamming_pkg.sv
// Shared constants and FSM state type for the Hamming(7,4) arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;

  // Output-register occupancy state (legacy-compatible constant encoding)
  typedef logic [0:0] state_t;
  localparam state_t ST_EMPTY = 1'b0;
  localparam state_t ST_FULL  = 1'b1;

  // Syndrome of a 7-bit codeword; each bit is the parity over one check group.
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
    logic [SYN_W-1:0] s;
    s[0] = c[6] ^ c[4] ^ c[2] ^ c[0];
    s[1] = c[5] ^ c[4] ^ c[1] ^ c[0];
    s[2] = c[3] ^ c[2] ^ c[1] ^ c[0];
    return s;
  endfunction

endpackage

// File: rtl/hamming_arbiter_if.sv
// Requester and result handshake bundle for the Hamming arbiter.
// Latency: n/a (wiring only).
// Backpressure: reqN_ready / out_ready carry the valid-ready flow control.
interface hamming_arbiter_if;
  import hamming_pkg::*;

  logic              req0_valid;
  logic [CODE_W-1:0] req0_code;
  logic              req0_ready;
  logic              req1_valid;
  logic [CODE_W-1:0] req1_code;
  logic              req1_ready;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_data;
  logic              out_src;
  logic              out_corrected;

  // Requesters and result consumer side
  modport master (
    output req0_valid, req0_code, req1_valid, req1_code, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src, out_corrected
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src, out_corrected
  );

endinterface

// File: rtl/hamming_syndrome_fix.sv
// Single-error correction of a 7-bit Hamming codeword.
// Latency: purely combinational.
// Backpressure: none.
module hamming_syndrome_fix
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [CODE_W-1:0] fixed_o,
  output logic              syn_nz_o
);

  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] flip_mask;

  assign syn      = calc_syndrome(code_i);
  assign syn_nz_o = |syn;

  // A nonzero syndrome s points at bit (7 - s); zero syndrome flips nothing.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip_mask[i] = (syn == SYN_W'(CODE_W - i));
    end
  end

  assign fixed_o = code_i ^ flip_mask;

endmodule

// File: rtl/hamming_arbiter.sv
// Round-robin arbiter of two codeword requesters into one corrected-result register.
// Latency: 1 cycle from accepted request to out_valid.
// Backpressure: requesters see ready only when the result register is empty or draining.
module hamming_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hamming_arbiter_if.slave  bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1
);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              corr_q, corr_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              can_accept;
  logic              grant;
  logic              grant_vld;
  logic              accept;
  logic [CODE_W-1:0] sel_code;
  logic [CODE_W-1:0] fixed_code;
  logic              syn_nz;

  assign can_accept = (state_q == ST_EMPTY) || bus.out_ready;

  // Grant: lone requester wins; on a tie, the one not granted last time wins
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign grant_vld      = grant ? bus.req1_valid : bus.req0_valid;
  assign accept         = can_accept && grant_vld;
  assign bus.req0_ready = can_accept && !grant;
  assign bus.req1_ready = can_accept && grant;
  assign sel_code       = grant ? bus.req1_code : bus.req0_code;

  hamming_syndrome_fix u_fix (
    .code_i   (sel_code),
    .fixed_o  (fixed_code),
    .syn_nz_o (syn_nz)
  );

  // Result register and occupancy: accept reloads (even while draining), drain empties
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    src_d        = src_q;
    corr_d       = corr_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = ST_FULL;
      data_d       = fixed_code;
      src_d        = grant;
      corr_d       = syn_nz;
      last_grant_d = grant;
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Saturating per-requester error counters; clear beats a same-cycle increment
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept && syn_nz) begin
      if (!grant && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
      if (grant && cnt1_q != '1)  cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any held result immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      src_q        <= 1'b0;
      corr_q       <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      src_q        <= src_d;
      corr_q       <= corr_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.out_valid     = (state_q == ST_FULL);
  assign bus.out_data      = data_q;
  assign bus.out_src       = src_q;
  assign bus.out_corrected = corr_q;
  assign err_cnt0          = cnt0_q;
  assign err_cnt1          = cnt1_q;

endmodule

// File: tb/tb_hamming_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a reference model.
// Latency: model expects results one clock after acceptance.
// Backpressure: model derives expected ready from occupancy and out_ready.
module tb_hamming_arbiter;
  import hamming_pkg::*;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic clr_cnt;
  logic [TB_CNT_W-1:0] err_cnt0, err_cnt1;

  hamming_arbiter_if bus();

  hamming_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_cnt  (clr_cnt),
    .err_cnt0 (err_cnt0),
    .err_cnt1 (err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit       m_full;
  bit [6:0] m_data;
  bit       m_src;
  bit       m_corr;
  int       m_last;
  int       m_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A word is a codeword when every parity check group sums to even
  function automatic bit is_cw(input bit [6:0] c);
    bit [6:0] g0, g1, g2;
    g0 = 7'b1010101;
    g1 = 7'b0110011;
    g2 = 7'b0001111;
    return ($countones(c & g0) % 2 == 0) && ($countones(c & g1) % 2 == 0) &&
           ($countones(c & g2) % 2 == 0);
  endfunction

  // Nearest codeword by search over single-bit flips
  function automatic bit [6:0] m_fix(input bit [6:0] c);
    bit [6:0] t;
    if (is_cw(c)) return c;
    for (int i = 0; i < 7; i++) begin
      t = c ^ (7'd1 << i);
      if (is_cw(t)) return t;
    end
    return c;
  endfunction

  function automatic bit [6:0] bad_code();
    bit [6:0] c;
    c = 7'($urandom);
    if (is_cw(c)) c = c ^ 7'd1;
    return c;
  endfunction

  task automatic reset_model();
    m_full = 0; m_data = '0; m_src = 0; m_corr = 0; m_last = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".vld"},  32'(bus.out_valid),     32'(m_full));
    chk({tag, ".data"}, 32'(bus.out_data),      32'(m_data));
    chk({tag, ".src"},  32'(bus.out_src),       32'(m_src));
    chk({tag, ".corr"}, 32'(bus.out_corrected), 32'(m_corr));
    chk({tag, ".cnt0"}, 32'(err_cnt0),          32'(m_cnt[0]));
    chk({tag, ".cnt1"}, 32'(err_cnt1),          32'(m_cnt[1]));
  endtask

  // One clock: check readies before the edge, advance model, check outputs after
  task automatic cycle(input string tag);
    int       g;
    bit       can, acc, clr, ordy, v0, v1;
    bit [6:0] code;
    #1;
    v0 = bus.req0_valid; v1 = bus.req1_valid;
    if (v0 && v1) g = (m_last == 0) ? 1 : 0;
    else          g = v1 ? 1 : 0;
    ordy = bus.out_ready;
    clr  = clr_cnt;
    can  = !m_full || ordy;
    chk({tag, ".rdy0"}, 32'(bus.req0_ready), 32'(can && g == 0));
    chk({tag, ".rdy1"}, 32'(bus.req1_ready), 32'(can && g == 1));
    acc  = can && ((g == 1) ? v1 : v0);
    code = (g == 1) ? bus.req1_code : bus.req0_code;
    @(posedge clk);
    if (clr) begin
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (acc && !is_cw(code) && m_cnt[g] < CNT_MAX) begin
      m_cnt[g]++;
    end
    if (acc) begin
      m_full = 1; m_data = m_fix(code); m_src = (g == 1);
      m_corr = !is_cw(code); m_last = g;
    end else if (m_full && ordy) begin
      m_full = 0;
    end
    #1;
    check_outs(tag);
  endtask

  task automatic drive(input bit v0, input bit [6:0] c0, input bit v1, input bit [6:0] c1,
                       input bit ordy, input bit clr);
    bus.req0_valid = v0; bus.req0_code = c0;
    bus.req1_valid = v1; bus.req1_code = c1;
    bus.out_ready  = ordy;
    clr_cnt        = clr;
  endtask

  initial begin
    bit [6:0] held;
    drive(0, '0, 0, '0, 0, 0);
    rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst_n = 1'b1;

    // Clean codeword from requester 0
    drive(1, 7'b0000000, 0, '0, 1, 0);
    cycle("clean0");
    chk("clean0.exp_data", 32'(bus.out_data), 32'd0);
    chk("clean0.exp_corr", 32'(bus.out_corrected), 32'd0);

    // Bit-0 error from requester 1
    drive(0, '0, 1, 7'b0000001, 1, 0);
    cycle("err1");
    chk("err1.exp_data", 32'(bus.out_data), 32'd0);
    chk("err1.exp_src",  32'(bus.out_src), 32'd1);
    chk("err1.exp_corr", 32'(bus.out_corrected), 32'd1);
    chk("err1.exp_cnt1", 32'(err_cnt1), 32'd1);

    // Sustained tie alternates with no bubble
    for (int i = 0; i < 4; i++) begin
      drive(1, 7'($urandom), 1, 7'($urandom), 1, 0);
      cycle("rr");
      chk("rr.exp_src", 32'(bus.out_src), 32'(i % 2));
      chk("rr.exp_vld", 32'(bus.out_valid), 32'd1);
    end

    // Stall while full, then same-cycle drain and accept
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'($urandom), 1, 7'($urandom), 0, 0);
      cycle("stall");
      chk("stall.frozen", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    cycle("drain_acc");
    chk("drain_acc.vld", 32'(bus.out_valid), 32'd1);

    // Saturation and clear priority on requester 0
    drive(0, '0, 0, '0, 1, 1);
    cycle("clr");
    for (int i = 0; i < 5; i++) begin
      drive(1, bad_code(), 0, '0, 1, 0);
      cycle("sat");
    end
    chk("sat.exp_cnt0", 32'(err_cnt0), 32'd3);
    drive(1, bad_code(), 0, '0, 1, 1);
    cycle("clr_pri");
    chk("clr_pri.exp_cnt0", 32'(err_cnt0), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 7'($urandom), 1'($urandom), 7'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    // Asynchronous reset while full with a nonzero counter
    drive(1, bad_code(), 0, '0, 0, 0);
    cycle("pre_rst");
    #1;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outs("async_rst");
    #2;
    rst_n = 1'b1;
    drive(1, 7'($urandom), 1, 7'($urandom), 1, 0);
    cycle("post_rst");
    chk("post_rst.exp_src", 32'(bus.out_src), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
